fft_bin_reader: RTL and testbench
=================================

# fft_bin_reader

Drains a completed 512-point FFT result out of whichever `dual_RAM` bank holds it and streams the lower N/2 bins downstream with a valid/ready handshake. For each bin it emits the complex value and its power, re² + im². It is the read-side counterpart to the butterfly pipeline that writes the banks, and it feeds the tuner's peak-detection stage. It drives the bank's address port and consumes that bank's read data; the bank mux is outside this block.

## Interface
Parameters:
- `bit_width`, 16: width of each of Re and Im.
- `N`, 512: FFT length.
- `M`, log2(N) = 9: RAM address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle pulse meaning the FFT is done and the result bank is stable. Sampled only in IDLE.
- `rd_adr` out M: address presented to the result bank.
- `rd_data` in 2*bit_width: {Re, Im} with Re in the upper half. Valid one cycle after `rd_adr` (synchronous read).
- `busy` out 1: high from the first address issue until the last bin's handshake.
- `done` out 1: one-cycle pulse after the last bin is accepted.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_bin` out M-1: bin index, 0..N/2-1.
- `out_re`, `out_im` out bit_width each: signed components.
- `out_power` out 2*bit_width: unsigned re² + im².

## Operation
- States:
  - IDLE: go to RUN on `start`.
  - RUN: issue addresses 0..N/2-1. Go to DRAIN once address N/2-1 has been issued.
  - DRAIN: wait for the last handshake, then go to IDLE with `done`.
- Only bins 0..N/2-1 are read, because the input is real and the upper half is conjugate-symmetric.
- The address counter advances only when fewer than 2 reads are outstanding or buffered. A skid buffer of depth 2 captures `rd_data` so that no bin is lost or duplicated under any `out_ready` pattern.
- A handshake is `out_valid && out_ready`. The beat must be held stable (all `out_*` unchanged) while `out_valid && !out_ready`.
- Arithmetic:
  - Re and Im are signed two's complement.
  - Products are full-width, 2*bit_width signed. Their sum is unsigned 2*bit_width.
  - The worst case, 2·(−2^15)² = 2^31, fits, so the sum never saturates.
- `start` while not IDLE is ignored.
- `reset` in any state:
  - next edge returns to IDLE;
  - clears the skid buffer and discards in-flight data;
  - `out_valid`, `busy` and `done` go to 0.
- Reset values: `rd_adr` 0, `out_bin` 0, `out_re`/`out_im`/`out_power` 0, `out_valid`/`busy`/`done` 0.
- `rd_adr` wrap: the counter stops at N/2-1 and never wraps into the upper half.

## Timing
- Cycle numbering: cycle 0 is the edge where `start` is sampled.
- Cycle 1: `rd_adr` = 0 and `busy` = 1.
- Cycle 2: `rd_data` = mem[0] is captured.
- Cycle 3: `out_valid` = 1 with bin 0, so latency from `start` to first beat is 3 cycles.
- With `out_ready` held high: one bin per cycle, bin 255 in cycle 258, `busy` falls and `done` pulses in cycle 259. `start` is accepted again from cycle 259.
- Backpressure: each cycle of `out_ready` low delays all later beats by exactly one cycle. There are no bubbles after `out_ready` returns high.
- `out_power` is registered in the same stage as `out_re`/`out_im` and corresponds to the same bin.

## Structure
- `fft_pkg` holds:
  - `bit_width`, `N` and `M` defaults, plus the `log2` function;
  - `cplx_t` packed struct {Re, Im}, each signed `bit_width`;
  - the reader state enum (IDLE/RUN/DRAIN).
- `dual_RAM` and `twiddle_ROM` import the same package.
- Sub-module `fft_skid_buf`: a 2-entry valid/ready buffer carrying {bin, cplx_t}. The squarer sits after it in the output register stage.
- Top level: FSM, address counter, outstanding-read counter (0..2), power compute and output register.

## Test plan
- Bank preloaded with mem[k] = {k, −k}, `out_ready` = 1, `start` pulse:
  - beats k = 0..255 in cycles 3..258;
  - `out_power` = 2k², e.g. bin 255 → 130050;
  - `done` pulses in cycle 259.
- Same bank, `out_ready` toggled with pattern 1,0,0,1 repeating: exactly 256 beats, in order, with no duplicates, and the beat held stable during every stall.
- mem[0] = {−32768, −32768}: `out_power` = 2147483648 (0x8000_0000). mem[1] = {32767, 0}: `out_power` = 1073676289.
- `start` pulsed again in cycle 100 of a run: ignored, still exactly 256 beats and one `done`.
- `reset` asserted in cycle 50 with `out_valid` high:
  - the next cycle has all outputs at reset values and the FSM in IDLE;
  - a new `start` yields bin 0 three cycles later.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared FFT definitions: default sizes, a constant log2, the complex sample type and the reader states.
package fft_pkg;

    localparam int bit_width = 16;
    localparam int N         = 512;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++)
            if ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int M = log2(N);

    typedef struct packed {
        logic signed [bit_width-1:0] re;
        logic signed [bit_width-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} rd_state_t;

endpackage

// File: rtl/fft_skid_buf.sv
// Two-entry FIFO that absorbs RAM read data already in flight when the output stalls.
module fft_skid_buf #(
    parameter int M = fft_pkg::M
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           push,
    input  logic [M-2:0]   push_bin,
    input  fft_pkg::cplx_t push_data,
    input  logic           pop,
    output logic           pop_valid,
    output logic [M-2:0]   pop_bin,
    output fft_pkg::cplx_t pop_data
);
    logic [M-2:0]   bin_mem  [2];
    fft_pkg::cplx_t data_mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic [1:0]     count;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            bin_mem[wr_ptr]  <= push_bin;
            data_mem[wr_ptr] <= push_data;
        end
    end

    assign pop_valid = (count != 2'd0);
    assign pop_bin   = bin_mem[rd_ptr];
    assign pop_data  = data_mem[rd_ptr];

endmodule

// File: rtl/fft_bin_reader.sv
// Reads bins 0..N/2-1 of a completed FFT bank and streams {bin, re, im, re^2+im^2}
// over valid/ready. Path: address issue -> synchronous RAM -> skid buffer -> squarer/output register.
module fft_bin_reader #(
    parameter int bit_width = fft_pkg::bit_width,
    parameter int N         = fft_pkg::N,
    parameter int M         = fft_pkg::log2(N)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic [M-1:0]                rd_adr,
    input  logic [2*bit_width-1:0]      rd_data,
    output logic                        busy,
    output logic                        done,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [M-2:0]                out_bin,
    output logic signed [bit_width-1:0] out_re,
    output logic signed [bit_width-1:0] out_im,
    output logic [2*bit_width-1:0]      out_power
);
    import fft_pkg::*;

    localparam int LAST_BIN = N / 2 - 1;

    rd_state_t    state, state_nxt;
    logic [1:0]   pend_cnt;
    logic         issue;
    logic         pop;
    logic         last_adr;
    logic         last_hs;
    logic         vld_p0;
    logic [M-2:0] bin_p0;
    logic         vld_p1;
    logic [M-2:0] bin_p1;
    cplx_t        data_p1;

    // Products are sign-extended to full width; the sum is reinterpreted as unsigned so 2^31 fits.
    function automatic logic [2*bit_width-1:0] sq_power(input cplx_t v);
        logic signed [2*bit_width-1:0] re_x, im_x, re_sq, im_sq;
        re_x  = {{bit_width{v.re[bit_width-1]}}, v.re};
        im_x  = {{bit_width{v.im[bit_width-1]}}, v.im};
        re_sq = re_x * re_x;
        im_sq = im_x * im_x;
        return $unsigned(re_sq) + $unsigned(im_sq);
    endfunction

    assign pop      = vld_p1 && (!out_valid || out_ready);
    assign last_adr = (rd_adr == M'(LAST_BIN));
    assign last_hs  = out_valid && out_ready && (out_bin == (M-1)'(LAST_BIN));
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        unique case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                // A slot freed by this cycle's pop counts, otherwise throughput halves.
                if (pend_cnt < 2'd2 || pop) begin
                    issue = 1'b1;
                    if (last_adr) state_nxt = DRAIN;
                end
            end
            DRAIN: if (last_hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0: address issued, read in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rd_adr   <= '0;
            pend_cnt <= 2'd0;
            vld_p0   <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= (state == DRAIN) && last_hs;
            pend_cnt <= pend_cnt + {1'b0, issue} - {1'b0, pop};
            vld_p0   <= issue;
            if (state == IDLE && start)
                rd_adr <= '0;
            else if (issue && !last_adr)
                rd_adr <= rd_adr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        bin_p0 <= rd_adr[M-2:0];
    end

    // Stage p1: RAM data captured into the skid buffer
    fft_skid_buf #(.M(M)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .push      (vld_p0),
        .push_bin  (bin_p0),
        .push_data (cplx_t'(rd_data)),
        .pop       (pop),
        .pop_valid (vld_p1),
        .pop_bin   (bin_p1),
        .pop_data  (data_p1)
    );

    // Stage p2: squarer and output register, loaded only when the current beat is free
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_re    <= '0;
            out_im    <= '0;
            out_power <= '0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_bin   <= bin_p1;
            out_re    <= data_p1.re;
            out_im    <= data_p1.im;
            out_power <= sq_power(data_p1);
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bin_reader.sv
// Self-checking bench for fft_bin_reader: bank model, per-scenario tasks, reference model from the bank contents.
module tb_fft_bin_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [8:0]  rd_adr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_bin;
    logic signed [15:0] out_re;
    logic signed [15:0] out_im;
    logic [31:0] out_power;

    fft_bin_reader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rd_adr    (rd_adr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bin   (out_bin),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_power (out_power)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    always @(posedge clk) rd_data <= mem[rd_adr];

    int checks = 0;
    int errors = 0;

    int     q_bin[$];
    int     q_re[$];
    int     q_im[$];
    int     q_hs[$];
    longint q_pw[$];
    bit     rdy_hist [0:3100];
    int     exp_hs [0:255];

    int nb, nd, done_cyc, first_vld, unstable, busy1, busy_at_done, adr_hi;

    function automatic int exp_re(input int k);
        logic [31:0] w;
        w = mem[k];
        return int'($signed(w[31:16]));
    endfunction

    function automatic int exp_im(input int k);
        logic [31:0] w;
        w = mem[k];
        return int'($signed(w[15:0]));
    endfunction

    function automatic longint exp_pw(input int k);
        longint re, im;
        re = longint'(exp_re(k));
        im = longint'(exp_im(k));
        return re * re + im * im;
    endfunction

    // Beat k is accepted on the first ready edge after beat k-1; beat 0 is first offered at edge 4.
    task automatic compute_hs();
        int e;
        e = 4;
        for (int k = 0; k < 256; k++) begin
            while (e < 3000 && !rdy_hist[e]) e++;
            exp_hs[k] = e;
            e++;
        end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 512; k++) mem[k] = {k[15:0], 16'(-k)};
    endtask

    task automatic fill_random();
        for (int k = 0; k < 512; k++) mem[k] = $urandom();
    endtask

    // Pulse start, run the stream with the given ready mode, record beats and events.
    task automatic collect(input int mode, input int restart_cyc);
        bit          r;
        bit          prev_hold;
        logic [72:0] prev_beat, cur;
        q_bin.delete(); q_re.delete(); q_im.delete(); q_hs.delete(); q_pw.delete();
        for (int e = 0; e <= 3100; e++) rdy_hist[e] = 1'b0;
        nb = 0; nd = 0; done_cyc = -1; first_vld = -1; unstable = 0;
        busy1 = 0; busy_at_done = 1; adr_hi = 0;
        prev_hold = 1'b0; prev_beat = '0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3000 && !(nd > 0 && c > done_cyc + 6); c++) begin
            @(negedge clk);
            start = (c == restart_cyc);
            cur = {out_valid, out_bin, out_re, out_im, out_power};
            if (prev_hold && cur !== prev_beat) unstable++;
            if (out_valid && first_vld < 0) first_vld = c;
            if (c == 1) busy1 = busy;
            if (int'(rd_adr) > adr_hi) adr_hi = int'(rd_adr);
            if (done) begin
                nd++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    busy_at_done = busy;
                end
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = ((c + 1) % 4 == 0) || ((c + 1) % 4 == 3);
                default: r = ($urandom_range(0, 3) != 0);
            endcase
            out_ready = r;
            rdy_hist[c + 1] = r;
            if (out_valid && r) begin
                q_bin.push_back(int'(out_bin));
                q_re.push_back(int'(out_re));
                q_im.push_back(int'(out_im));
                q_pw.push_back(longint'(out_power));
                q_hs.push_back(c + 1);
                nb++;
            end
            prev_hold = out_valid && !r;
            prev_beat = cur;
        end
        start = 1'b0;
        out_ready = 1'b1;
        compute_hs();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rd_adr !== 9'd0)     begin errors++; $display("FAIL reset rd_adr: got %0d want 0", rd_adr); end
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (out_bin !== 8'd0)    begin errors++; $display("FAIL reset out_bin: got %0d want 0", out_bin); end
        checks++; if (out_re !== 16'sd0)   begin errors++; $display("FAIL reset out_re: got %0d want 0", out_re); end
        checks++; if (out_im !== 16'sd0)   begin errors++; $display("FAIL reset out_im: got %0d want 0", out_im); end
        checks++; if (out_power !== 32'd0) begin errors++; $display("FAIL reset out_power: got %0d want 0", out_power); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ramp();
        fill_ramp();
        collect(0, -1);
        checks++; if (nb !== 256) begin errors++; $display("FAIL ramp beat count: got %0d want 256", nb); end
        for (int k = 0; k < nb && k < 256; k++) begin
            checks++;
            if (q_bin[k] !== k || q_re[k] !== exp_re(k) || q_im[k] !== exp_im(k) || q_pw[k] !== exp_pw(k) || q_hs[k] !== exp_hs[k]) begin
                errors++;
                $display("FAIL ramp beat %0d: got bin=%0d re=%0d im=%0d pw=%0d edge=%0d want bin=%0d re=%0d im=%0d pw=%0d edge=%0d",
                         k, q_bin[k], q_re[k], q_im[k], q_pw[k], q_hs[k], k, exp_re(k), exp_im(k), exp_pw(k), exp_hs[k]);
            end
        end
        checks++; if (first_vld !== 3)  begin errors++; $display("FAIL ramp first valid cycle: got %0d want 3", first_vld); end
        checks++; if (done_cyc !== 259) begin errors++; $display("FAIL ramp done cycle: got %0d want 259", done_cyc); end
        checks++; if (nd !== 1)         begin errors++; $display("FAIL ramp done pulses: got %0d want 1", nd); end
        checks++; if (busy1 !== 1)      begin errors++; $display("FAIL ramp busy at cycle 1: got %0d want 1", busy1); end
        checks++; if (busy_at_done !== 0) begin errors++; $display("FAIL ramp busy at done: got %0d want 0", busy_at_done); end
        checks++; if (adr_hi > 255)     begin errors++; $display("FAIL ramp max rd_adr: got %0d want <= 255", adr_hi); end
        checks++;
        if (nb < 256 || q_pw[255] !== 64'd130050) begin
            errors++; $display("FAIL ramp bin 255 power: got %0d want 130050", (nb < 256) ? -1 : q_pw[255]);
        end
    endtask

    task automatic test_backpressure();
        fill_ramp();
        collect(1, -1);
        checks++; if (nb !== 256) begin errors++; $display("FAIL backpressure beat count: got %0d want 256", nb); end
        for (int k = 0; k < nb && k < 256; k++) begin
            checks++;
            if (q_bin[k] !== k || q_re[k] !== exp_re(k) || q_im[k] !== exp_im(k) || q_pw[k] !== exp_pw(k) || q_hs[k] !== exp_hs[k]) begin
                errors++;
                $display("FAIL backpressure beat %0d: got bin=%0d re=%0d pw=%0d edge=%0d want bin=%0d re=%0d pw=%0d edge=%0d",
                         k, q_bin[k], q_re[k], q_pw[k], q_hs[k], k, exp_re(k), exp_pw(k), exp_hs[k]);
            end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL backpressure stall stability: got %0d changes want 0", unstable); end
        checks++; if (nd !== 1)       begin errors++; $display("FAIL backpressure done pulses: got %0d want 1", nd); end
        checks++; if (done_cyc !== exp_hs[255]) begin errors++; $display("FAIL backpressure done cycle: got %0d want %0d", done_cyc, exp_hs[255]); end
    endtask

    task automatic test_extremes();
        fill_random();
        mem[0] = {16'h8000, 16'h8000};
        mem[1] = {16'h7fff, 16'h0000};
        collect(2, -1);
        checks++; if (nb !== 256) begin errors++; $display("FAIL extremes beat count: got %0d want 256", nb); end
        for (int k = 0; k < nb && k < 256; k++) begin
            checks++;
            if (q_bin[k] !== k || q_re[k] !== exp_re(k) || q_im[k] !== exp_im(k) || q_pw[k] !== exp_pw(k) || q_hs[k] !== exp_hs[k]) begin
                errors++;
                $display("FAIL extremes beat %0d: got bin=%0d re=%0d im=%0d pw=%0d edge=%0d want bin=%0d re=%0d im=%0d pw=%0d edge=%0d",
                         k, q_bin[k], q_re[k], q_im[k], q_pw[k], q_hs[k], k, exp_re(k), exp_im(k), exp_pw(k), exp_hs[k]);
            end
        end
        checks++;
        if (nb < 1 || q_pw[0] !== 64'h8000_0000) begin
            errors++; $display("FAIL extremes bin 0 power: got %0d want 2147483648", (nb < 1) ? -1 : q_pw[0]);
        end
        checks++;
        if (nb < 2 || q_pw[1] !== 64'd1073676289) begin
            errors++; $display("FAIL extremes bin 1 power: got %0d want 1073676289", (nb < 2) ? -1 : q_pw[1]);
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL extremes stall stability: got %0d changes want 0", unstable); end
        checks++; if (nd !== 1)       begin errors++; $display("FAIL extremes done pulses: got %0d want 1", nd); end
    endtask

    task automatic test_start_ignored();
        fill_random();
        collect(0, 100);
        checks++; if (nb !== 256) begin errors++; $display("FAIL restart beat count: got %0d want 256", nb); end
        for (int k = 0; k < nb && k < 256; k++) begin
            checks++;
            if (q_bin[k] !== k || q_pw[k] !== exp_pw(k) || q_re[k] !== exp_re(k) || q_im[k] !== exp_im(k)) begin
                errors++;
                $display("FAIL restart beat %0d: got bin=%0d pw=%0d want bin=%0d pw=%0d", k, q_bin[k], q_pw[k], k, exp_pw(k));
            end
        end
        checks++; if (nd !== 1)         begin errors++; $display("FAIL restart done pulses: got %0d want 1", nd); end
        checks++; if (done_cyc !== 259) begin errors++; $display("FAIL restart done cycle: got %0d want 259", done_cyc); end
    endtask

    task automatic test_reset_mid();
        fill_ramp();
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c <= 50; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset valid before reset: got %b want 1", out_valid); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL midreset out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL midreset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0)       begin errors++; $display("FAIL midreset done: got %b want 0", done); end
        checks++; if (rd_adr !== 9'd0)     begin errors++; $display("FAIL midreset rd_adr: got %0d want 0", rd_adr); end
        checks++; if (out_bin !== 8'd0)    begin errors++; $display("FAIL midreset out_bin: got %0d want 0", out_bin); end
        checks++; if (out_re !== 16'sd0 || out_im !== 16'sd0) begin errors++; $display("FAIL midreset re/im: got %0d/%0d want 0/0", out_re, out_im); end
        checks++; if (out_power !== 32'd0) begin errors++; $display("FAIL midreset out_power: got %0d want 0", out_power); end
        reset = 1'b0;
        collect(0, -1);
        checks++; if (first_vld !== 3) begin errors++; $display("FAIL midreset first valid cycle: got %0d want 3", first_vld); end
        checks++; if (nb !== 256)      begin errors++; $display("FAIL midreset beat count: got %0d want 256", nb); end
        for (int k = 0; k < nb && k < 256; k++) begin
            checks++;
            if (q_bin[k] !== k || q_re[k] !== exp_re(k) || q_im[k] !== exp_im(k) || q_pw[k] !== exp_pw(k) || q_hs[k] !== exp_hs[k]) begin
                errors++;
                $display("FAIL midreset beat %0d: got bin=%0d re=%0d pw=%0d edge=%0d want bin=%0d re=%0d pw=%0d edge=%0d",
                         k, q_bin[k], q_re[k], q_pw[k], q_hs[k], k, exp_re(k), exp_pw(k), exp_hs[k]);
            end
        end
        checks++; if (nd !== 1) begin errors++; $display("FAIL midreset done pulses: got %0d want 1", nd); end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 512; k++) mem[k] = '0;
        test_reset();
        test_ramp();
        test_backpressure();
        test_extremes();
        test_start_ignored();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
